m_alu_seq: RTL and testbench
============================

M_ALU_SEQ -- requirements
Module: m_alu_seq

Interface
REQ-001 SHALL have parameter OP_W, default 4: request opcode width.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid  input  1  request present.
REQ-005 SHALL have req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-006 SHALL have req_op  input  OP_W  opcode: 0 ADD, 1 AND, 2 XOR, 3 SHL, 4 SHR, 5 ASL, 6 ASR, 7 MUL, 8-15 invalid.
REQ-007 SHALL have req_a, req_b  input  32  operands.
REQ-008 SHALL have rsp_valid  output  1  response present.
REQ-009 SHALL have rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a rising edge.
REQ-010 SHALL have rsp_data  output  32  result.
REQ-011 SHALL have rsp_cmp  output  e_cmp_res  comparison of req_a vs req_b.
REQ-012 SHALL have core_op  output  e_core_op, core_a/core_b  output  32: drive to the shared ALU core.
REQ-013 SHALL have core_out  input  32, core_cmp  input  e_cmp_res: combinational core results, same cycle.
REQ-014 SHALL have busy  output  1  high whenever state != IDLE.

Function
REQ-015 SHALL implement states IDLE, EXEC, MUL, RESP; req_ready = (state == IDLE).
REQ-016 On accept, SHALL latch op/a/b and go IDLE->EXEC; no new accept until return to IDLE (no bypass).
REQ-017 In EXEC, SHALL drive core_op = mapped op (ADD for MUL/invalid), core_a = latched a, core_b = latched b; capture core_cmp into rsp_cmp.
REQ-018 In EXEC, for ops 0-6, SHALL capture core_out into rsp_data, go RESP; rsp_valid rises T+2 after accept at T.
REQ-019 For invalid ops, SHALL return rsp_data = 32'hffffffff with normal cmp, same T+2 latency.
REQ-020 For MUL, EXEC SHALL init acc=0, mc=a, mp=b and go MUL.
REQ-021 Each MUL cycle with mp != 0: core_op=ADD, core_a=acc, core_b=mc; acc <= mp[0] ? core_out : acc; mc <= mc<<1; mp <= mp>>1.
REQ-022 A MUL cycle with mp == 0 SHALL load rsp_data=acc and go RESP; product is low 32 bits (mod 2^32).
REQ-023 MUL rsp_valid SHALL rise at T+3+k, k = bit length of b (b=0 -> T+3; b=32'hffffffff -> T+35).
REQ-024 In IDLE and RESP, SHALL drive core_op=ADD, core_a=0, core_b=0.
REQ-025 In RESP, rsp_valid=1 and rsp_data/rsp_cmp SHALL hold stable until rsp_ready; then -> IDLE next edge.
REQ-026 rsp_ready while not in RESP SHALL have no effect; req_valid outside IDLE SHALL be ignored.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, rsp_valid=0, rsp_data=0, rsp_cmp=CMP_RES_EQ, acc/mc/mp=0, busy=0; req_ready=1 once released.
REQ-028 Reset during EXEC/MUL/RESP SHALL discard the in-flight operation; no response emitted afterwards.

Configuration
REQ-029 With ALU_SEQ_MUL_EN defined, SHALL implement MUL state and acc/mc/mp registers per REQ-020..023.
REQ-030 Without ALU_SEQ_MUL_EN, SHALL omit MUL state and registers; opcode 7 treated as invalid (REQ-019).

Verification
REQ-031 ADD a=5,b=3, rsp_ready=1 -> rsp_valid at T+2, rsp_data=8, rsp_cmp=CMP_RES_GT, req_ready at T+3.
REQ-032 op 12, a=b=7 -> rsp_data=32'hffffffff, rsp_cmp=CMP_RES_EQ at T+2.
REQ-033 MUL a=6,b=7 -> rsp_data=42 at T+6, CMP_RES_LT; MUL a=9,b=0 -> 0 at T+3; MUL a=b=32'hffffffff -> 1 at T+35.
REQ-034 SHR a=32'h80,b=4, rsp_ready=0 for 5 cycles -> rsp_data=8 held stable, req_valid ignored, accept only after handshake.
REQ-035 rst_n pulsed low mid-MUL (a=3,b=32'hffff) -> outputs reset immediately, no rsp_valid later; next ADD 1+1 -> 2.
REQ-036 Build without ALU_SEQ_MUL_EN: MUL a=2,b=3 -> rsp_data=32'hffffffff at T+2.

Source files
------------

// File: rtl/m_alu_seq_if.sv
// Request/response bus for the sequencing ALU front end, plus the shared enum types.
package m_alu_seq_pkg;
  typedef enum logic [2:0] {
    CORE_OP_ADD = 3'd0,
    CORE_OP_AND = 3'd1,
    CORE_OP_XOR = 3'd2,
    CORE_OP_SHL = 3'd3,
    CORE_OP_SHR = 3'd4,
    CORE_OP_ASL = 3'd5,
    CORE_OP_ASR = 3'd6
  } e_core_op;

  typedef enum logic [1:0] {
    CMP_RES_EQ = 2'd0,
    CMP_RES_LT = 2'd1,
    CMP_RES_GT = 2'd2
  } e_cmp_res;
endpackage

interface m_alu_seq_if
  import m_alu_seq_pkg::*;
#(
  parameter int unsigned OP_W = 4
);
  logic            req_valid;
  logic            req_ready;
  logic [OP_W-1:0] req_op;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  e_cmp_res        rsp_cmp;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_cmp
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_cmp
  );
endinterface

// File: rtl/m_alu_seq.sv
// Sequencer in front of a shared combinational ALU core. One request in flight at a time:
// IDLE -> EXEC -> (MUL loop) -> RESP -> IDLE.
// Optional shift-and-add multiplier enabled by defining ALU_SEQ_MUL_EN; without it
// opcode 7 is answered as an invalid opcode.
module m_alu_seq
  import m_alu_seq_pkg::*;
#(
  parameter int unsigned OP_W = 4  // must be >= 3 so the core opcode fits
) (
  input  logic        clk,
  input  logic        rst_n,
  m_alu_seq_if.slave  bus,
  output e_core_op    core_op,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic [31:0] core_out,
  input  e_cmp_res    core_cmp,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
`ifdef ALU_SEQ_MUL_EN
    StMul  = 2'd2,
`endif
    StResp = 2'd3
  } e_state;

  e_state          state_q;
  logic [OP_W-1:0] op_q;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_data_q;
  e_cmp_res        rsp_cmp_q;
`ifdef ALU_SEQ_MUL_EN
  logic [31:0]     acc_q;
  logic [31:0]     mc_q;
  logic [31:0]     mp_q;
  logic            op_is_mul;
  assign op_is_mul = (op_q == OP_W'(7));
`endif

  // Opcodes 0-6 map one-to-one onto the core opcodes.
  logic     op_is_alu;
  e_core_op op_mapped;
  assign op_is_alu = (op_q < OP_W'(7));
  assign op_mapped = op_is_alu ? e_core_op'(op_q[2:0]) : CORE_OP_ADD;

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_cmp   = rsp_cmp_q;
  assign busy          = (state_q != StIdle);

  // Core operand steering; the core result is consumed in the same cycle.
  always_comb begin
    core_op = CORE_OP_ADD;
    core_a  = '0;
    core_b  = '0;
    unique case (state_q)
      StExec: begin
        core_op = op_mapped;
        core_a  = a_q;
        core_b  = b_q;
      end
`ifdef ALU_SEQ_MUL_EN
      StMul: begin
        core_a = acc_q;
        core_b = mc_q;
      end
`endif
      default: ;
    endcase
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_cmp_q   <= CMP_RES_EQ;
`ifdef ALU_SEQ_MUL_EN
      acc_q       <= '0;
      mc_q        <= '0;
      mp_q        <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            state_q <= StExec;
          end
        end
        StExec: begin
          rsp_cmp_q <= core_cmp;
          if (op_is_alu) begin
            rsp_data_q  <= core_out;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
`ifdef ALU_SEQ_MUL_EN
          end else if (op_is_mul) begin
            acc_q   <= '0;
            mc_q    <= a_q;
            mp_q    <= b_q;
            state_q <= StMul;
`endif
          end else begin
            rsp_data_q  <= '1;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        StMul: begin
          // One multiplier bit per cycle; finishes once no set bits remain.
          if (mp_q != '0) begin
            if (mp_q[0]) acc_q <= core_out;
            mc_q <= mc_q << 1;
            mp_q <= mp_q >> 1;
          end else begin
            rsp_data_q  <= acc_q;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
`endif
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_m_alu_seq.sv
// Randomized + directed bench for m_alu_seq. Provides a behavioural ALU core and
// checks every response against a plain-arithmetic reference model.
module tb_m_alu_seq;
  import m_alu_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  e_core_op    core_op;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic [31:0] core_out;
  e_cmp_res    core_cmp;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  m_alu_seq_if #(.OP_W(4)) bus ();

  m_alu_seq #(.OP_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .core_op  (core_op),
    .core_a   (core_a),
    .core_b   (core_b),
    .core_out (core_out),
    .core_cmp (core_cmp),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU core (unsigned compare).
  always_comb begin
    case (core_op)
      CORE_OP_ADD: core_out = core_a + core_b;
      CORE_OP_AND: core_out = core_a & core_b;
      CORE_OP_XOR: core_out = core_a ^ core_b;
      CORE_OP_SHL: core_out = core_a << core_b[4:0];
      CORE_OP_SHR: core_out = core_a >> core_b[4:0];
      CORE_OP_ASL: core_out = core_a << core_b[4:0];
      CORE_OP_ASR: core_out = 32'($signed(core_a) >>> core_b[4:0]);
      default:     core_out = '0;
    endcase
    core_cmp = (core_a < core_b) ? CMP_RES_LT : (core_a > core_b) ? CMP_RES_GT : CMP_RES_EQ;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int bit_len(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // Reference: result, comparison and cycles from accept to rsp_valid.
  function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output e_cmp_res c, output int lat);
    lat = 2;
    c   = (a < b) ? CMP_RES_LT : (a > b) ? CMP_RES_GT : CMP_RES_EQ;
    case (op)
      0: d = a + b;
      1: d = a & b;
      2: d = a ^ b;
      3: d = a << b[4:0];
      4: d = a >> b[4:0];
      5: d = a << b[4:0];
      6: d = 32'($signed(a) >>> b[4:0]);
`ifdef ALU_SEQ_MUL_EN
      7: begin
        d   = a * b;
        lat = 3 + bit_len(b);
      end
`endif
      default: d = 32'hffffffff;
    endcase
  endfunction

  // Issue one request starting at a negedge; hold rsp_ready low for 'stall' RESP cycles.
  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b,
                       input int stall);
    logic [31:0] exp_d;
    e_cmp_res    exp_c;
    int          lat;
    int          n;
    model(op, a, b, exp_d, exp_c, lat);
    check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = 4'(op);
    bus.req_a     = a;
    bus.req_b     = b;
    bus.rsp_ready = (stall == 0);
    @(negedge clk);
    if (stall > 0) begin
      // Must be ignored while busy.
      bus.req_op = 4'd0;
      bus.req_a  = $urandom;
      bus.req_b  = $urandom;
    end else begin
      bus.req_valid = 1'b0;
    end
    n = 1;
    while (!bus.rsp_valid && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_eq("latency", 32'(n), 32'(lat));
    check_eq("rsp_data", bus.rsp_data, exp_d);
    check_eq("rsp_cmp", 32'(bus.rsp_cmp), 32'(exp_c));
    check_eq("busy_resp", 32'(busy), 32'd1);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("hold_data", bus.rsp_data, exp_d);
      check_eq("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_eq("post_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("post_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          seen;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_rsp_data", bus.rsp_data, 32'd0);
    check_eq("rst_rsp_cmp", 32'(bus.rsp_cmp), 32'(CMP_RES_EQ));
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_core_a", core_a, 32'd0);

    // Directed cases.
    do_op(0, 32'd5, 32'd3, 0);
    do_op(12, 32'd7, 32'd7, 0);
    do_op(7, 32'd6, 32'd7, 0);
    do_op(7, 32'd9, 32'd0, 0);
    do_op(7, 32'hffffffff, 32'hffffffff, 0);
    do_op(4, 32'h80, 32'd4, 5);
    do_op(7, 32'd2, 32'd3, 0);

    // Reset pulsed while an operation is in flight.
    bus.req_valid = 1'b1;
    bus.req_op    = 4'd7;
    bus.req_a     = 32'd3;
    bus.req_b     = 32'hffff;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_data", bus.rsp_data, 32'd0);
    check_eq("mid_rst_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check_eq("no_stale_rsp", 32'(seen), 32'd0);
    do_op(0, 32'd1, 32'd1, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = ra;
      do_op(int'($urandom_range(0, 15)), ra, rb, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
